// File: rtl/dcache_sa_if.sv
// Core load/store port and memory-bus port of the set-associative data cache.
// slave = cache side, master = core plus bus-arbiter side.
interface dcache_sa_if;
   logic [31:0] addr;
   logic        rd_req;
   logic        wr_req;
   logic [3:0]  wr_be;
   logic [31:0] wr_data;
   logic        inval;
   logic        rw_wait;
   logic [31:0] rd_data;
   logic        bus_req;
   logic        bus_ack;
   logic [31:0] bus_addr;
   logic [31:0] bus_rdata;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_rd;
   logic        bus_wr;
   logic        bus_ready;

   modport slave (
      input  addr, rd_req, wr_req, wr_be, wr_data, inval, bus_ack, bus_rdata, bus_ready,
      output rw_wait, rd_data, bus_req, bus_addr, bus_wdata, bus_be, bus_rd, bus_wr
   );
   modport master (
      output addr, rd_req, wr_req, wr_be, wr_data, inval, bus_ack, bus_rdata, bus_ready,
      input  rw_wait, rd_data, bus_req, bus_addr, bus_wdata, bus_be, bus_rd, bus_wr
   );
endinterface

// File: rtl/dcache_sa.sv
// Write-through, no-write-allocate 1/2-way data cache; read hits are zero-wait, misses fill a
// whole line (WORDS_PER_LINE+1 cycles minimum), writes hold rw_wait until the bus beat completes.
module dcache_sa #(
   parameter int LINES          = 16,
   parameter int WORDS_PER_LINE = 16,
   parameter int WAYS           = 2
) (
   input logic        clk,
   input logic        rst_n,
   dcache_sa_if.slave cif
);
   localparam int WB   = $clog2(WORDS_PER_LINE);
   localparam int OFF  = WB + 2;
   localparam int IDX  = $clog2(LINES);
   localparam int TAGW = 32 - OFF - IDX;

   typedef enum logic {S_IDLE, S_FILL} state_t;

   state_t           r_state;
   logic [WB-1:0]    r_fill_pos;
   logic             r_victim;
   logic [31:OFF]    r_line;
   logic [LINES-1:0] r_valid [WAYS];
   logic [LINES-1:0] r_lru;
   logic [TAGW-1:0]  r_tag   [WAYS][LINES];
   logic [31:0]      r_data  [WAYS][LINES*WORDS_PER_LINE];

   logic [TAGW-1:0] w_tag;
   logic [IDX-1:0]  w_idx;
   logic [WB-1:0]   w_word;
   logic [WAYS-1:0] w_hit_vec;
   logic            w_hit, w_hit_way, w_victim;
   logic            w_wr, w_beat, w_fill_ok, w_fill_beat, w_fill_done, w_wr_done, w_start;
   logic            w_bus_rd, w_bus_wr;

   assign w_tag  = cif.addr[31 -: TAGW];
   assign w_idx  = cif.addr[OFF +: IDX];
   assign w_word = cif.addr[2 +: WB];

   always_comb begin
      w_hit_vec = '0;
      for (int w = 0; w < WAYS; w++)
         w_hit_vec[w] = r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag);
   end

   assign w_hit     = |w_hit_vec;
   assign w_hit_way = (WAYS == 2) && w_hit_vec[WAYS-1];

   // Prefer an empty way (way 0 first); only a full set consults the LRU bit.
   always_comb begin
      w_victim = 1'b0;
      if (WAYS == 2 && r_valid[0][w_idx])
         w_victim = r_valid[WAYS-1][w_idx] ? r_lru[w_idx] : 1'b1;
   end

   assign w_wr        = cif.wr_req && !cif.rd_req;
   assign w_beat      = cif.bus_ack && cif.bus_ready;
   assign w_start     = (r_state == S_IDLE) && cif.rd_req && !w_hit;
   assign w_fill_ok   = (r_state == S_FILL) && cif.rd_req && !cif.inval &&
                        (cif.addr[31:OFF] == r_line);
   assign w_fill_beat = w_fill_ok && w_beat;
   assign w_fill_done = w_fill_beat && (r_fill_pos == WB'(WORDS_PER_LINE - 1));
   assign w_wr_done   = w_wr && w_beat && w_hit;
   assign w_bus_rd    = w_fill_ok && cif.bus_ack;
   assign w_bus_wr    = w_wr && cif.bus_ack;

   assign cif.rw_wait = (cif.rd_req && !w_hit) || (w_wr && !w_beat);
   assign cif.bus_req = (cif.rd_req && !w_hit) || w_wr;
   assign cif.bus_rd  = w_bus_rd;
   assign cif.bus_wr  = w_bus_wr;
   assign cif.rd_data = r_data[w_hit_way][{w_idx, w_word}];

   always_comb begin
      cif.bus_addr  = '0;
      cif.bus_wdata = '0;
      cif.bus_be    = '0;
      if (w_bus_rd) begin
         cif.bus_addr = {cif.addr[31:OFF], r_fill_pos, 2'b00};
         cif.bus_be   = 4'hF;
      end else if (w_bus_wr) begin
         cif.bus_addr  = cif.addr;
         cif.bus_wdata = cif.wr_data;
         cif.bus_be    = cif.wr_be;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_fill_pos <= '0;
         r_victim   <= 1'b0;
         r_line     <= '0;
         r_lru      <= '0;
         for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_start) begin
               r_state                  <= S_FILL;
               r_victim                 <= w_victim;
               r_line                   <= cif.addr[31:OFF];
               r_fill_pos               <= '0;
               r_valid[w_victim][w_idx] <= 1'b0;
            end
            S_FILL: if (!w_fill_ok) begin
               r_state    <= S_IDLE;
               r_fill_pos <= '0;
            end else if (w_fill_beat) begin
               r_fill_pos <= r_fill_pos + 1'b1;
               if (w_fill_done) begin
                  r_state                  <= S_IDLE;
                  r_fill_pos               <= '0;
                  r_valid[r_victim][w_idx] <= 1'b1;
                  r_lru[w_idx]             <= ~r_victim;
               end
            end
            default: r_state <= S_IDLE;
         endcase
         if (cif.rd_req && w_hit) r_lru[w_idx] <= ~w_hit_way;
         // Invalidate wins over a fill completing in the same cycle.
         if (cif.inval)
            for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_fill_beat) r_data[r_victim][{w_idx, r_fill_pos}] <= cif.bus_rdata;
      if (w_fill_done) r_tag[r_victim][w_idx] <= w_tag;
      if (w_wr_done)
         for (int b = 0; b < 4; b++)
            if (cif.wr_be[b])
               r_data[w_hit_way][{w_idx, w_word}][8*b +: 8] <= cif.wr_data[8*b +: 8];
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk)
      if (cif.rd_req && cif.wr_req)
         $display("dcache_sa warning: rd_req and wr_req together, write ignored");
`endif
endmodule
